// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: merges the instruction-fetch client (read-only) and the
// load/store client onto the single rw_* request port of the AXI read/write
// bridge. Load/store has priority; a starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive load/store grants while fetch is pending.
//
// Ports:
//   clock, reset          sole clock; synchronous active-low reset
//   if_*                  fetch client: valid/addr/size in, ready/data/resp out
//   mem_*                 load/store client: valid/req/addr/size/wdata in,
//                         ready/data/resp out
//   rw_*                  bridge side: valid/req/addr/size/wdata out,
//                         ready/rdata/resp in
// All outputs are registered.
module mem_req_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_valid_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic [1:0]            if_size_i,
    output logic                  if_ready_o,
    output logic [DATA_WIDTH-1:0] if_data_read_o,
    output logic [1:0]            if_resp_o,
    input  logic                  mem_valid_i,
    input  logic                  mem_req_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [1:0]            mem_size_i,
    input  logic [DATA_WIDTH-1:0] mem_data_write_i,
    output logic                  mem_ready_o,
    output logic [DATA_WIDTH-1:0] mem_data_read_o,
    output logic [1:0]            mem_resp_o,
    output logic                  rw_valid_o,
    input  logic                  rw_ready_i,
    output logic                  rw_req_o,
    output logic [ADDR_WIDTH-1:0] rw_addr_o,
    output logic [1:0]            rw_size_o,
    output logic [DATA_WIDTH-1:0] rw_data_write_o,
    input  logic [DATA_WIDTH-1:0] rw_data_read_i,
    input  logic [1:0]            rw_resp_i
);

    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BUSY_IF  = 3'd1,
        BUSY_MEM = 3'd2,
        DONE_IF  = 3'd3,
        DONE_MEM = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  rw_valid_q, rw_valid_d;
    logic                  rw_req_q, rw_req_d;
    logic [ADDR_WIDTH-1:0] rw_addr_q, rw_addr_d;
    logic [1:0]            rw_size_q, rw_size_d;
    logic [DATA_WIDTH-1:0] rw_wdata_q, rw_wdata_d;
    logic                  if_ready_q, if_ready_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [1:0]            if_resp_q, if_resp_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic [1:0]            mem_resp_q, mem_resp_d;
    logic                  grant_mem_c;

    // Load/store wins unless fetch is pending and has been starved long enough
    assign grant_mem_c = mem_valid_i && (!if_valid_i || (starve_q < STARVE_LIM));

    // Next-state and output register computation
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        rw_valid_d  = rw_valid_q;
        rw_req_d    = rw_req_q;
        rw_addr_d   = rw_addr_q;
        rw_size_d   = rw_size_q;
        rw_wdata_d  = rw_wdata_q;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_resp_d   = if_resp_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_resp_d  = mem_resp_q;

        unique case (state_q)
            IDLE: begin
                if (grant_mem_c) begin
                    state_d    = BUSY_MEM;
                    rw_valid_d = 1'b1;
                    rw_req_d   = mem_req_i;
                    rw_addr_d  = mem_addr_i;
                    rw_size_d  = mem_size_i;
                    rw_wdata_d = mem_data_write_i;
                    // Only grants that bypass a waiting fetch count toward starvation
                    if (if_valid_i && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (if_valid_i) begin
                    state_d    = BUSY_IF;
                    rw_valid_d = 1'b1;
                    rw_req_d   = 1'b0;
                    rw_addr_d  = if_addr_i;
                    rw_size_d  = if_size_i;
                    rw_wdata_d = '0;
                    starve_d   = '0;
                end
            end
            BUSY_IF: begin
                if (rw_ready_i) begin
                    state_d    = DONE_IF;
                    rw_valid_d = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = rw_data_read_i;
                    if_resp_d  = rw_resp_i;
                end
            end
            BUSY_MEM: begin
                if (rw_ready_i) begin
                    state_d     = DONE_MEM;
                    rw_valid_d  = 1'b0;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = rw_data_read_i;
                    mem_resp_d  = rw_resp_i;
                end
            end
            DONE_IF, DONE_MEM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            rw_valid_q  <= 1'b0;
            rw_req_q    <= 1'b0;
            rw_addr_q   <= '0;
            rw_size_q   <= '0;
            rw_wdata_q  <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            if_resp_q   <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            mem_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            rw_valid_q  <= rw_valid_d;
            rw_req_q    <= rw_req_d;
            rw_addr_q   <= rw_addr_d;
            rw_size_q   <= rw_size_d;
            rw_wdata_q  <= rw_wdata_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            if_resp_q   <= if_resp_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            mem_resp_q  <= mem_resp_d;
        end
    end

    assign rw_valid_o      = rw_valid_q;
    assign rw_req_o        = rw_req_q;
    assign rw_addr_o       = rw_addr_q;
    assign rw_size_o       = rw_size_q;
    assign rw_data_write_o = rw_wdata_q;
    assign if_ready_o      = if_ready_q;
    assign if_data_read_o  = if_rdata_q;
    assign if_resp_o       = if_resp_q;
    assign mem_ready_o     = mem_ready_q;
    assign mem_data_read_o = mem_rdata_q;
    assign mem_resp_o      = mem_resp_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter with hand-computed expectations.
module tb_mem_req_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid_i;
    logic [63:0] if_addr_i;
    logic [1:0]  if_size_i;
    logic        if_ready_o;
    logic [63:0] if_data_read_o;
    logic [1:0]  if_resp_o;
    logic        mem_valid_i;
    logic        mem_req_i;
    logic [63:0] mem_addr_i;
    logic [1:0]  mem_size_i;
    logic [63:0] mem_data_write_i;
    logic        mem_ready_o;
    logic [63:0] mem_data_read_o;
    logic [1:0]  mem_resp_o;
    logic        rw_valid_o;
    logic        rw_ready_i;
    logic        rw_req_o;
    logic [63:0] rw_addr_o;
    logic [1:0]  rw_size_o;
    logic [63:0] rw_data_write_o;
    logic [63:0] rw_data_read_i;
    logic [1:0]  rw_resp_i;

    int n_checks = 0;
    int n_pass   = 0;

    mem_req_arbiter #(
        .ADDR_WIDTH  (64),
        .DATA_WIDTH  (64),
        .STARVE_LIMIT(4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .if_valid_i      (if_valid_i),
        .if_addr_i       (if_addr_i),
        .if_size_i       (if_size_i),
        .if_ready_o      (if_ready_o),
        .if_data_read_o  (if_data_read_o),
        .if_resp_o       (if_resp_o),
        .mem_valid_i     (mem_valid_i),
        .mem_req_i       (mem_req_i),
        .mem_addr_i      (mem_addr_i),
        .mem_size_i      (mem_size_i),
        .mem_data_write_i(mem_data_write_i),
        .mem_ready_o     (mem_ready_o),
        .mem_data_read_o (mem_data_read_o),
        .mem_resp_o      (mem_resp_o),
        .rw_valid_o      (rw_valid_o),
        .rw_ready_i      (rw_ready_i),
        .rw_req_o        (rw_req_o),
        .rw_addr_o       (rw_addr_o),
        .rw_size_o       (rw_size_o),
        .rw_data_write_o (rw_data_write_o),
        .rw_data_read_i  (rw_data_read_i),
        .rw_resp_i       (rw_resp_i)
    );

    always #5 clock = ~clock;

    // Advance one cycle; outputs are stable 1ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Bridge model: wait for a request, hold it lat cycles, pulse ready.
    // Returns in the cycle where the client ready pulse is visible.
    task automatic serve(input int lat, input logic [63:0] rdata, input logic [1:0] resp,
                         output logic [63:0] addr_seen);
        int n = 0;
        logic [63:0] wd;
        while (!rw_valid_o && n < 20) begin
            tick();
            n++;
        end
        check("rw_valid_wait", 64'(rw_valid_o), 64'd1);
        addr_seen = rw_addr_o;
        wd        = rw_data_write_o;
        for (int i = 1; i < lat; i++) begin
            tick();
            check("rw_valid_hold", 64'(rw_valid_o), 64'd1);
            check("rw_addr_hold", rw_addr_o, addr_seen);
            check("rw_wdata_hold", rw_data_write_o, wd);
        end
        rw_ready_i     = 1'b1;
        rw_data_read_i = rdata;
        rw_resp_i      = resp;
        tick();
        rw_ready_i     = 1'b0;
        rw_data_read_i = '0;
        rw_resp_i      = '0;
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] exp_order [6];

        reset            = 1'b0;
        if_valid_i       = 1'b0;
        if_addr_i        = '0;
        if_size_i        = '0;
        mem_valid_i      = 1'b0;
        mem_req_i        = 1'b0;
        mem_addr_i       = '0;
        mem_size_i       = '0;
        mem_data_write_i = '0;
        rw_ready_i       = 1'b0;
        rw_data_read_i   = '0;
        rw_resp_i        = '0;
        tick();
        tick();
        check("rst_rw_valid", 64'(rw_valid_o), 64'd0);
        check("rst_if_ready", 64'(if_ready_o), 64'd0);
        check("rst_mem_ready", 64'(mem_ready_o), 64'd0);
        check("rst_rw_addr", rw_addr_o, 64'd0);
        reset = 1'b1;
        tick();

        // Fetch only
        if_valid_i = 1'b1;
        if_addr_i  = 64'h8000_0000;
        if_size_i  = 2'd3;
        tick();
        check("f_rw_valid", 64'(rw_valid_o), 64'd1);
        check("f_rw_req", 64'(rw_req_o), 64'd0);
        check("f_rw_addr", rw_addr_o, 64'h8000_0000);
        check("f_rw_size", 64'(rw_size_o), 64'd3);
        check("f_rw_wdata", rw_data_write_o, 64'd0);
        serve(5, 64'h0000_0000_0010_0093, 2'd0, a);
        if_valid_i = 1'b0;
        check("f_if_ready", 64'(if_ready_o), 64'd1);
        check("f_if_data", if_data_read_o, 64'h0000_0000_0010_0093);
        check("f_if_resp", 64'(if_resp_o), 64'd0);
        check("f_mem_ready", 64'(mem_ready_o), 64'd0);
        check("f_rw_valid_drop", 64'(rw_valid_o), 64'd0);
        tick();
        check("f_if_ready_once", 64'(if_ready_o), 64'd0);
        check("f_if_data_hold", if_data_read_o, 64'h0000_0000_0010_0093);
        tick();

        // Simultaneous requests: MEM first, then IF
        if_valid_i  = 1'b1;
        if_addr_i   = 64'h8000_0000;
        mem_valid_i = 1'b1;
        mem_req_i   = 1'b0;
        mem_addr_i  = 64'h8000_1000;
        mem_size_i  = 2'd3;
        tick();
        check("s_first_addr", rw_addr_o, 64'h8000_1000);
        serve(2, 64'h1111_2222_3333_4444, 2'd0, a);
        mem_valid_i = 1'b0;
        check("s_mem_ready", 64'(mem_ready_o), 64'd1);
        check("s_mem_data", mem_data_read_o, 64'h1111_2222_3333_4444);
        check("s_if_ready", 64'(if_ready_o), 64'd0);
        tick();
        check("s_gap_valid", 64'(rw_valid_o), 64'd0);
        tick();
        check("s_second_valid", 64'(rw_valid_o), 64'd1);
        check("s_second_addr", rw_addr_o, 64'h8000_0000);
        serve(1, 64'h5555_6666_7777_8888, 2'd0, a);
        if_valid_i = 1'b0;
        check("s_if_ready", 64'(if_ready_o), 64'd1);
        check("s_if_data", if_data_read_o, 64'h5555_6666_7777_8888);
        check("s_mem_data_hold", mem_data_read_o, 64'h1111_2222_3333_4444);
        tick();
        tick();

        // Starvation: both held, expect M,M,M,M,I,M
        exp_order[0] = 64'h200; exp_order[1] = 64'h200; exp_order[2] = 64'h200;
        exp_order[3] = 64'h200; exp_order[4] = 64'h100; exp_order[5] = 64'h200;
        if_valid_i  = 1'b1;
        if_addr_i   = 64'h100;
        mem_valid_i = 1'b1;
        mem_addr_i  = 64'h200;
        for (int g = 0; g < 6; g++) begin
            serve(1, 64'(g), 2'd0, a);
            check($sformatf("starve_grant%0d", g), a, exp_order[g]);
        end
        if_valid_i  = 1'b0;
        mem_valid_i = 1'b0;
        tick();
        tick();

        // Store with input changes during BUSY
        mem_valid_i      = 1'b1;
        mem_req_i        = 1'b1;
        mem_addr_i       = 64'h8000_2008;
        mem_size_i       = 2'd3;
        mem_data_write_i = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        check("st_rw_req", 64'(rw_req_o), 64'd1);
        check("st_rw_addr", rw_addr_o, 64'h8000_2008);
        check("st_rw_wdata", rw_data_write_o, 64'hDEAD_BEEF_CAFE_F00D);
        check("st_rw_size", 64'(rw_size_o), 64'd3);
        mem_addr_i       = 64'hAAAA_0000;
        mem_data_write_i = 64'h0;
        mem_req_i        = 1'b0;
        serve(4, 64'h0000_0000_0000_1234, 2'd0, a);
        mem_valid_i = 1'b0;
        check("st_mem_ready", 64'(mem_ready_o), 64'd1);
        check("st_mem_data", mem_data_read_o, 64'h1234);
        check("st_rw_req_hold", 64'(rw_req_o), 64'd1);
        tick();
        check("st_mem_ready_once", 64'(mem_ready_o), 64'd0);
        tick();

        // Error response on fetch, address change ignored
        if_valid_i = 1'b1;
        if_addr_i  = 64'h8000_0040;
        if_size_i  = 2'd2;
        tick();
        check("e_rw_addr", rw_addr_o, 64'h8000_0040);
        if_addr_i = 64'h9999_0000;
        serve(3, 64'hBAD0, 2'b10, a);
        if_valid_i = 1'b0;
        check("e_if_ready", 64'(if_ready_o), 64'd1);
        check("e_if_resp", 64'(if_resp_o), 64'd2);
        check("e_rw_addr_kept", rw_addr_o, 64'h8000_0040);
        tick();
        tick();

        // Reset during BUSY_MEM
        mem_valid_i = 1'b1;
        mem_req_i   = 1'b0;
        mem_addr_i  = 64'h8000_3000;
        tick();
        check("r_busy_valid", 64'(rw_valid_o), 64'd1);
        tick();
        reset = 1'b0;
        tick();
        reset       = 1'b1;
        mem_valid_i = 1'b0;
        check("r_rw_valid", 64'(rw_valid_o), 64'd0);
        check("r_rw_addr", rw_addr_o, 64'd0);
        check("r_if_data", if_data_read_o, 64'd0);
        check("r_if_resp", 64'(if_resp_o), 64'd0);
        check("r_mem_data", mem_data_read_o, 64'd0);
        rw_ready_i     = 1'b1;
        rw_data_read_i = 64'hFFFF;
        tick();
        rw_ready_i     = 1'b0;
        rw_data_read_i = '0;
        check("r_stray_mem", 64'(mem_ready_o), 64'd0);
        tick();
        check("r_stray_mem2", 64'(mem_ready_o), 64'd0);
        check("r_stray_if", 64'(if_ready_o), 64'd0);
        mem_valid_i = 1'b1;
        mem_addr_i  = 64'h8000_4000;
        tick();
        check("r_resume_addr", rw_addr_o, 64'h8000_4000);
        serve(2, 64'h4242, 2'd0, a);
        mem_valid_i = 1'b0;
        check("r_resume_ready", 64'(mem_ready_o), 64'd1);
        check("r_resume_data", mem_data_read_o, 64'h4242);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Two-client request arbiter between the CPU core and the AXI read/write bridge (axi_rw), on its upstream side.
- Merges the instruction-fetch client (read-only) and the load/store client (read or write) onto the single rw_* request port of axi_rw.
- Registers the granted request and returns the bridge's read data and response to the owning client.
- Load/store has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_WIDTH, 64, address width of all request ports.
- DATA_WIDTH, 64, data width of all read/write data ports.
- STARVE_LIMIT, 4, number of consecutive load/store grants with fetch pending before fetch is forced; must be 1..15.

Ports:
- clock  in  1  sole clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- if_valid_i  in  1  fetch request pending
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_size_i  in  2  fetch size code, same encoding as rw_size_o
- if_ready_o  out  1  one-cycle fetch completion pulse
- if_data_read_o  out  DATA_WIDTH  fetch data, valid while if_ready_o=1
- if_resp_o  out  2  fetch response, valid while if_ready_o=1
- mem_valid_i  in  1  load/store request pending
- mem_req_i  in  1  0=REQ_READ, 1=REQ_WRITE
- mem_addr_i  in  ADDR_WIDTH  load/store address
- mem_size_i  in  2  load/store size code
- mem_data_write_i  in  DATA_WIDTH  store data
- mem_ready_o  out  1  one-cycle load/store completion pulse
- mem_data_read_o  out  DATA_WIDTH  load data, valid while mem_ready_o=1
- mem_resp_o  out  2  load/store response, valid while mem_ready_o=1
- rw_valid_o  out  1  request to axi_rw
- rw_ready_i  in  1  axi_rw completion pulse
- rw_req_o  out  1  read/write select to axi_rw
- rw_addr_o  out  ADDR_WIDTH  request address
- rw_size_o  out  2  request size
- rw_data_write_o  out  DATA_WIDTH  write data
- rw_data_read_i  in  DATA_WIDTH  read data, sampled when rw_ready_i=1
- rw_resp_i  in  2  response, sampled when rw_ready_i=1

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM. All outputs are registered.
- Reset (reset=0 at an edge, from any state, including mid-transaction):
  - state goes to IDLE, starvation counter goes to 0.
  - Every output goes to 0.
  - Any in-flight bridge transaction is discarded; axi_rw is reset by the same signal.
- IDLE, grant decision (evaluated every cycle):
  - mem_valid_i=1 and (if_valid_i=0 or starve_cnt<STARVE_LIMIT) -> BUSY_MEM.
  - else if_valid_i=1 -> BUSY_IF.
  - else stay in IDLE.
- On the grant edge:
  - Latch addr, size, req and write data into the rw_* registers.
  - Set rw_valid_o=1, so it is visible in the cycle after the request is sampled.
  - For an IF grant: rw_req_o=0 and rw_data_write_o=0.
- Starvation counter:
  - A MEM grant with if_valid_i=1 increments the counter, saturating at STARVE_LIMIT.
  - An IF grant clears it to 0.
  - A MEM grant with if_valid_i=0 leaves it unchanged.
- BUSY_x:
  - rw_* outputs are held stable; client input changes are ignored.
  - On rw_ready_i=1: capture rw_data_read_i and rw_resp_i into the client's data/resp registers, drop rw_valid_o, go to DONE_x.
  - rw_ready_i while in IDLE or DONE_x is ignored.
- DONE_x:
  - x_ready_o=1 for exactly this cycle; x_data_read_o and x_resp_o hold the captured values.
  - Next state is IDLE.
  - Client data/resp outputs keep their last value until the next completion for that client.
- Client contract: a client that sees x_ready_o=1 presents its next request (or drops valid) in the same cycle. IDLE samples it one cycle later.
- Latency:
  - Request sampled in IDLE at cycle N -> rw_valid_o=1 at N+1.
  - rw_ready_i at cycle M -> x_ready_o at M+1 -> IDLE at M+2.
  - Minimum gap between bridge requests is 2 cycles with rw_valid_o=0.
- Write completions: mem_data_read_o gets rw_data_read_i as returned, unmodified.
- Error responses (rw_resp_i!=0) are passed through unchanged; no retry.
- No address or size checks; all fields pass through unmodified.

Test Plan:
- Fetch only: if_valid_i=1, addr 0x80000000, size 3; bridge ready after 5 cycles with data 0x0000000000100093, resp 0 -> rw_valid_o rises 1 cycle after sampling with rw_req_o=0; if_ready_o pulses once with that data; mem_ready_o stays 0.
- Simultaneous: both valid in IDLE, mem read 0x80001000 -> MEM served first, then IF at 0x80000000. rw_addr_o sequence is 0x80001000, then 0x80000000.
- Starvation: if_valid_i and mem_valid_i held 1 continuously, STARVE_LIMIT=4 -> grant order MEM, MEM, MEM, MEM, IF, MEM, ...
- Store: mem_req_i=1, addr 0x80002008, data 0xDEADBEEFCAFEF00D, size 3 -> rw_req_o=1 with those values, stable for the whole BUSY period; mem_ready_o pulses once after rw_ready_i.
- Error and stability: bridge returns resp 2'b10 on a fetch; if_addr_i changes during BUSY_IF -> if_resp_o=2'b10; rw_addr_o stays the original address.
- Reset mid-op: reset=0 during BUSY_MEM -> next edge all outputs 0, state IDLE; a later rw_ready_i produces no client pulse; normal operation resumes after reset=1.
